i2c_cmd_seq: RTL

- Hardware command sequencer that drives the i2c_master cmd/dat/ws/stat_out interface from a small programmable command memory.
- It replaces the host or bench stepping: strobe a command, wait for DON, on ERR compare the status against the expected value and issue a clear.
- READ results are captured into an on-chip result buffer.
- Sits between a host register interface and one i2c_master instance; used for board bring-up scripts and for self-checking chain regressions.

---
 rtl/i2c_cmd_seq_if.sv | 29 ++
 rtl/i2c_cmd_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_seq_if.sv
// Sequencer <-> i2c_master command/status link.
// The master modport is the sequencer side (drives strobes); the slave modport is the
// i2c_master side (returns status and read data).
interface i2c_cmd_seq_if #(
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned STAT_W = 8
);
    logic [CMD_W-1:0]  cmd;
    logic [7:0]        dat;
    logic              ws;
    logic [STAT_W-1:0] stat;
    logic [7:0]        dat_out;

    modport master (
        output cmd,
        output dat,
        output ws,
        input  stat,
        input  dat_out
    );

    modport slave (
        input  cmd,
        input  dat,
        input  ws,
        output stat,
        output dat_out
    );
endinterface

// File: rtl/i2c_cmd_seq.sv
// Command sequencer for one i2c_master: steps a small program memory, strobes each
// command, waits for DON/ERR with a timeout, clears expected errors and captures READ
// results into a result buffer.
module i2c_cmd_seq #(
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      RDEPTH    = 16,
    parameter int unsigned      CMD_W     = 8,
    parameter int unsigned      STAT_W    = 8,
    parameter int unsigned      SB_DON    = 0,
    parameter int unsigned      SB_ERR    = 1,
    parameter logic [CMD_W-1:0] CMD_CLRS  = '0,
    parameter logic [CMD_W-1:0] READ_MASK = '0,
    parameter int unsigned      TMO_CYC   = 1000000,
    localparam int unsigned     PAW       = $clog2(DEPTH),
    localparam int unsigned     RAW       = (RDEPTH > 1) ? $clog2(RDEPTH) : 1,
    localparam int unsigned     PW        = CMD_W + 8 + STAT_W + 1
) (
    input  logic              i_clk,
    input  logic              i_aresetn,
    input  logic              i_prog_we,
    input  logic [PAW-1:0]    i_prog_addr,
    input  logic [PW-1:0]     i_prog_wdata,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic [PAW-1:0]    o_fail_idx,
    output logic [STAT_W-1:0] o_fail_stat,
    output logic [RAW:0]      o_res_cnt,
    output logic              o_res_ovf,
    input  logic [RAW-1:0]    i_res_addr,
    output logic [7:0]        o_res_data,
    i2c_cmd_seq_if.master     m_if
);
    localparam int unsigned TW = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StIssue, StHold, StWait, StClr, StClrh, StFin
    } state_e;

    state_e r_state, w_state_d;

    logic [PW-1:0]     r_prog [DEPTH];
    logic [7:0]        r_res  [RDEPTH];
    logic [PAW-1:0]    r_pc;
    logic [CMD_W-1:0]  r_cmd;
    logic [7:0]        r_dat;
    logic [STAT_W-1:0] r_exp;
    logic              r_last;
    logic [TW-1:0]     r_tmo;
    logic              r_fail;
    logic [PAW-1:0]    r_fail_idx;
    logic [STAT_W-1:0] r_fail_stat;
    logic [RAW:0]      r_res_cnt;
    logic              r_res_ovf;
    logic [7:0]        r_res_data;

    logic [PW-1:0] w_fetch;
    logic          w_err, w_don, w_match, w_is_read, w_tmo_exp, w_end, w_res_full;
    logic          w_ws, w_res_we;

    assign w_fetch    = r_prog[r_pc];
    assign w_err      = m_if.stat[SB_ERR];
    assign w_don      = m_if.stat[SB_DON];
    assign w_match    = (m_if.stat == r_exp);
    // r_cmd still holds the entry's command while in WAIT
    assign w_is_read  = |(r_cmd & READ_MASK);
    assign w_tmo_exp  = (r_tmo <= TW'(1));
    assign w_end      = r_last || (r_pc == PAW'(DEPTH - 1));
    assign w_res_full = (r_res_cnt == (RAW + 1)'(RDEPTH));
    assign w_res_we   = (r_state == StWait) && !w_err && w_don && w_is_read && !w_res_full;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) r_state <= StIdle;
        else            r_state <= w_state_d;
    end

    // Next-state decode and strobe/status outputs
    always_comb begin
        w_state_d = r_state;
        w_ws      = 1'b0;
        o_done    = 1'b0;
        o_busy    = (r_state != StIdle) && (r_state != StFin);
        unique case (r_state)
            StIdle:  if (i_start) w_state_d = StFetch;
            StFetch: w_state_d = StIssue;
            StIssue: begin
                w_ws      = 1'b1;
                w_state_d = StHold;
            end
            StHold:  w_state_d = StWait;
            StWait: begin
                if (w_err)          w_state_d = w_match ? StClr : StFin;
                else if (w_don)     w_state_d = w_end ? StFin : StFetch;
                else if (w_tmo_exp) w_state_d = StFin;
            end
            StClr: begin
                w_ws      = 1'b1;
                w_state_d = StClrh;
            end
            StClrh:  w_state_d = w_end ? StFin : StFetch;
            StFin: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Sequencer datapath: pc, master drive values, timeout, run status
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_pc        <= '0;
            r_cmd       <= '0;
            r_dat       <= '0;
            r_exp       <= '0;
            r_last      <= 1'b0;
            r_tmo       <= '0;
            r_fail      <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_stat <= '0;
            r_res_cnt   <= '0;
            r_res_ovf   <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_res_data <= r_res[i_res_addr];
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_pc      <= '0;
                        r_res_cnt <= '0;
                        r_fail    <= 1'b0;
                        r_res_ovf <= 1'b0;
                    end
                end
                StFetch: begin
                    r_last <= w_fetch[PW-1];
                    r_cmd  <= w_fetch[PW-2 -: CMD_W];
                    r_dat  <= w_fetch[STAT_W +: 8];
                    r_exp  <= w_fetch[STAT_W-1:0];
                end
                StHold: r_tmo <= TW'(TMO_CYC);
                StWait: begin
                    if (w_err) begin
                        if (w_match) begin
                            r_cmd <= CMD_CLRS;
                        end else begin
                            r_fail      <= 1'b1;
                            r_fail_idx  <= r_pc;
                            r_fail_stat <= m_if.stat;
                        end
                    end else if (w_don) begin
                        if (w_is_read) begin
                            if (w_res_full) r_res_ovf <= 1'b1;
                            else            r_res_cnt <= r_res_cnt + 1'b1;
                        end
                        if (!w_end) r_pc <= r_pc + 1'b1;
                    end else if (w_tmo_exp) begin
                        r_fail      <= 1'b1;
                        r_fail_idx  <= r_pc;
                        r_fail_stat <= '1;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                StClrh: if (!w_end) r_pc <= r_pc + 1'b1;
                default: ;
            endcase
        end
    end

    // Program memory: host writes accepted only while idle; contents survive reset
    always_ff @(posedge i_clk) begin
        if ((r_state == StIdle) && i_prog_we) r_prog[i_prog_addr] <= i_prog_wdata;
    end

    // Result buffer capture of successful READ data
    always_ff @(posedge i_clk) begin
        if (w_res_we) r_res[r_res_cnt[RAW-1:0]] <= m_if.dat_out;
    end

    assign m_if.cmd    = r_cmd;
    assign m_if.dat    = r_dat;
    assign m_if.ws     = w_ws;
    assign o_fail      = r_fail;
    assign o_fail_idx  = r_fail_idx;
    assign o_fail_stat = r_fail_stat;
    assign o_res_cnt   = r_res_cnt;
    assign o_res_ovf   = r_res_ovf;
    assign o_res_data  = r_res_data;
endmodule
